// File: rtl/mux_pkg.sv
// mux_pkg: definitions shared by the 4:1 multiplexer scan controller.
// Holds the controller state encoding, the channel index type and the
// number of multiplexer channels that one scan visits.
package mux_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] chan_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_controller_if.sv
// mux_scan_controller_if: bundles the controller's request, multiplexer and
// result signals.
//   start  : scan request toward the controller
//   w      : multiplexer output toward the controller
//   s0, s1 : select lines from the controller to the multiplexer
//   busy   : scan in progress
//   done   : one-cycle pulse when result is updated
//   result : four sampled bits, result[i] taken with select == i
// modport master is the controller side; modport slave is the requester
// plus multiplexer side.
interface mux_scan_controller_if;

    logic       start;
    logic       w;
    logic       s0;
    logic       s1;
    logic       busy;
    logic       done;
    logic [3:0] result;

    modport master (
        input  start, w,
        output s0, s1, busy, done, result
    );

    modport slave (
        output start, w,
        input  s0, s1, busy, done, result
    );

endinterface

// File: rtl/mux_sync2.sv
// mux_sync2: two-flop synchronizer for a single asynchronous input.
//   clk : destination clock
//   rst : asynchronous active-high reset, both stages clear to 0
//   d   : asynchronous input
//   q   : synchronized output, two clk cycles behind d
module mux_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mux_scan_controller.sv
// mux_scan_controller: steps the 4:1 multiplexer select lines through
// channels 0..3. Each channel is held for DWELL cycles, and w is sampled
// once per channel. The four samples are then published on result together
// with a one-cycle done pulse.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : mux_scan_controller_if.master (start, w, s0, s1, busy, done, result)
// Parameters: DWELL cycles per channel (2..255); SETTLE cycles from a select
// change to the sample point (SETTLE < DWELL); CW is the dwell counter width.
// Optional macro MUX_SCAN_SYNC_EN: w passes through mux_sync2 before it is
// sampled. The sample point then moves two cycles later, so it still sees
// the same w value. done and busy timing do not change.
module mux_scan_controller
    import mux_pkg::*;
#(
    parameter int DWELL  = 4,
    parameter int SETTLE = 1,
    parameter int CW     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_scan_controller_if.master bus
);

    logic w_s;

`ifdef MUX_SCAN_SYNC_EN
    localparam logic [CW-1:0] SAMPLE_CNT = CW'(SETTLE + 2);

    if (SETTLE + 2 >= DWELL) begin : g_bad_settle
        $error("mux_scan_controller: SETTLE+2 must be less than DWELL");
    end

    mux_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.w),
        .q   (w_s)
    );
`else
    localparam logic [CW-1:0] SAMPLE_CNT = CW'(SETTLE);

    assign w_s = bus.w;
`endif

    localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

    state_t        state_d, state_q;
    chan_t         chan_d, chan_q;
    chan_t         sel_d, sel_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [3:0]    scratch_d, scratch_q;
    logic [3:0]    result_d, result_q;
    logic          busy_d, busy_q;
    logic          done_d, done_q;

    // The select register is updated on the same edge as chan. s1 and s0
    // therefore always change together.
    // The last channel's sample can fall on its final dwell edge. result is
    // taken from scratch_d so that this bit is included.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        scratch_d = scratch_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                sel_d = '0;
                if (bus.start) begin
                    state_d   = SCAN;
                    chan_d    = '0;
                    cnt_d     = '0;
                    scratch_d = '0;
                    busy_d    = 1'b1;
                end
            end

            SCAN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SAMPLE_CNT) begin
                    scratch_d[chan_q] = w_s;
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (chan_q == chan_t'(NUM_CH - 1)) begin
                        state_d  = DONE;
                        chan_d   = '0;
                        sel_d    = '0;
                        result_d = scratch_d;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        chan_d = chan_q + 1'b1;
                        sel_d  = chan_q + 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and every output register clear immediately on reset. An
    // aborted scan therefore publishes nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            chan_q    <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            scratch_q <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.s0     = sel_q[0];
    assign bus.s1     = sel_q[1];
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mux_scan_controller.sv
// tb_mux_scan_controller: scoreboard bench for mux_scan_controller with
// DWELL=4 and SETTLE=1, driving w from a modelled 4:1 multiplexer (a,b,c,d).
// Each accepted scan pushes {expected result, expected done cycle}. A
// monitor pops one entry per done pulse. The monitor also checks the select
// sequence and the busy length.
module tb_mux_scan_controller;

    localparam int DWELL  = 4;
    localparam int SETTLE = 1;
    localparam int SCAN_CYCLES = 4 * DWELL;

    typedef struct {
        logic [3:0] res;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   cycle_count = 0;
    int   busy_run = 0;
    int   acc;
    exp_t exp_q[$];
    exp_t mon_e;

    mux_scan_controller_if bus ();

    mux_scan_controller #(
        .DWELL  (DWELL),
        .SETTLE (SETTLE),
        .CW     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock and an edge counter that names each rising edge.
    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    // Behavioural 4:1 multiplexer: w follows the selected input.
    always_comb begin
        case ({bus.s1, bus.s0})
            2'b00:   bus.w = a;
            2'b01:   bus.w = b;
            2'b10:   bus.w = c;
            default: bus.w = d;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ia, input logic ib,
                                 input logic ic, input logic id);
        a = ia;
        b = ib;
        c = ic;
        d = id;
    endtask

    // Pulse start for one edge and return the number of the accepting edge.
    task automatic pulseStart(output int accept_cycle);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        accept_cycle = cycle_count;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("scoreboard_drain", exp_q.size(), 0);
    endtask

    task automatic checkIdleOutputs(input string tag, input logic [3:0] res);
        checkOutput({tag, "_s0"}, bus.s0, 1'b0);
        checkOutput({tag, "_s1"}, bus.s1, 1'b0);
        checkOutput({tag, "_busy"}, bus.busy, 1'b0);
        checkOutput({tag, "_done"}, bus.done, 1'b0);
        checkOutput({tag, "_result"}, bus.result, res);
    endtask

    // Monitor: select follows busy time / DWELL. done must match the oldest
    // expectation, and it must end a busy run of exactly 4*DWELL cycles.
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (bus.busy) begin
                checkOutput("select_in_scan", {bus.s1, bus.s0}, busy_run / DWELL);
                busy_run++;
            end else begin
                checkOutput("select_idle", {bus.s1, bus.s0}, 0);
            end
            if (bus.done) begin
                checkOutput("busy_length", busy_run, SCAN_CYCLES);
                busy_run = 0;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_done: done at cycle %0d with nothing expected",
                             cycle_count);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("result", bus.result, mon_e.res);
                    checkOutput("done_cycle", cycle_count, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        applyStimulus(0, 0, 0, 0);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset", 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single scan, a=0 b=1 c=0 d=1
        applyStimulus(0, 1, 0, 1);
        pulseStart(acc);
        exp_q.push_back('{4'b1010, acc + SCAN_CYCLES});
        waitDrain(40);
        repeat (3) @(negedge clk);

        // start held high for 40 cycles: back-to-back scans 18 cycles apart
        applyStimulus(1, 1, 0, 0);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        acc = cycle_count;
        exp_q.push_back('{4'b0011, acc + 16});
        exp_q.push_back('{4'b0011, acc + 34});
        exp_q.push_back('{4'b0011, acc + 52});
        repeat (39) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        waitDrain(40);
        repeat (3) @(negedge clk);

        // Reset during channel 2 after a completed 1010 scan
        applyStimulus(0, 1, 0, 1);
        pulseStart(acc);
        exp_q.push_back('{4'b1010, acc + SCAN_CYCLES});
        waitDrain(40);
        checkOutput("result_before_abort", bus.result, 4'b1010);
        repeat (2) @(negedge clk);
        pulseStart(acc);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkIdleOutputs("async_reset", 4'b0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checkIdleOutputs("after_abort", 4'b0000);

        // c toggled around the channel-2 sample point
        applyStimulus(0, 0, 0, 0);
        pulseStart(acc);
        exp_q.push_back('{4'b0100, acc + SCAN_CYCLES});
        repeat (8) @(posedge clk);
        #1;
        c = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        c = 1'b0;
        waitDrain(40);
        repeat (3) @(negedge clk);

        // start pulses during SCAN and during DONE are ignored
        applyStimulus(0, 1, 0, 1);
        pulseStart(acc);
        exp_q.push_back('{4'b1010, acc + SCAN_CYCLES});
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitDrain(20);
        repeat (10) @(negedge clk);
        checkIdleOutputs("after_ignored_starts", 4'b1010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
